ternary_weight_sequencer: RTL and testbench

// - Upstream driver and downstream collector for ternary_perceptron: stores DEPTH packed ternary weight bytes,

---
 rtl/ternary_weight_sequencer.sv | 167 ++++++++++++++++
 tb/tb_ternary_weight_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ternary_weight_sequencer.sv
// Replays a bank of packed ternary weight bytes into a perceptron and tracks the argmax of its sums.
// Optional per-neuron fire mask output is enabled by defining TERNARY_FIRE_MASK_EN.
module ternary_weight_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          load_valid,
  input  logic [7:0]    load_data,
  output logic          load_ready,
  input  logic          start,
  output logic          busy,
  output logic [7:0]    weights_out,
  output logic          weights_valid,
  input  logic [3:0]    sum_in,
  output logic          done,
  output logic [AW-1:0] best_idx,
  output logic [3:0]    best_sum
`ifdef TERNARY_FIRE_MASK_EN
  ,
  output logic [DEPTH-1:0] fire_mask
`endif
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e        state_q;
  logic [7:0]    bank_q [DEPTH];
  logic [AW:0]   count_q;
  logic [AW:0]   len_q;
  logic [AW:0]   ptr_q;
  logic [7:0]    weights_out_q;
  logic          weights_valid_q;
  logic          busy_q;
  logic          done_q;
  logic [AW-1:0] best_idx_q;
  logic [3:0]    best_sum_q;
  logic          v0_q;
  logic          v1_q;
  logic [AW-1:0] i0_q;
  logic [AW-1:0] i1_q;

  logic bank_we;
  logic start_ok;
  logic take_sample;

  assign bank_we     = (state_q == IDLE) && !clear && load_valid && (count_q < DEPTH_C);
  assign start_ok    = (state_q == IDLE) && start && (count_q != '0);
  assign take_sample = v1_q && ((i1_q == '0) || ($signed(sum_in) > $signed(best_sum_q)));

  // Gated by reset so the port reads 0 while the block is held in reset.
  assign load_ready    = !reset && (state_q == IDLE) && (count_q < DEPTH_C);
  assign busy          = busy_q;
  assign weights_out   = weights_out_q;
  assign weights_valid = weights_valid_q;
  assign done          = done_q;
  assign best_idx      = best_idx_q;
  assign best_sum      = best_sum_q;

  // NOTE: the bank has no reset; count_q=0 makes stale entries unreachable, so it can map to plain storage.
  always_ff @(posedge clk) begin
    if (bank_we) begin
      bank_q[count_q[AW-1:0]] <= load_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      count_q         <= '0;
      len_q           <= '0;
      ptr_q           <= '0;
      weights_out_q   <= '0;
      weights_valid_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      best_idx_q      <= '0;
      best_sum_q      <= '0;
      v0_q            <= 1'b0;
      v1_q            <= 1'b0;
      i0_q            <= '0;
      i1_q            <= '0;
    end else begin
      done_q <= 1'b0;
      // The perceptron answers two edges after a weight set appears; this pair tracks which one.
      v1_q   <= v0_q;
      i1_q   <= i0_q;
      if (take_sample) begin
        best_sum_q <= sum_in;
        best_idx_q <= i1_q;
      end

      case (state_q)
        IDLE: begin
          if (clear) begin
            count_q <= '0;
          end else if (bank_we) begin
            count_q <= count_q + 1'b1;
          end
          if (start_ok) begin
            weights_out_q   <= bank_q[0];
            weights_valid_q <= 1'b1;
            busy_q          <= 1'b1;
            v0_q            <= 1'b1;
            i0_q            <= '0;
            ptr_q           <= {{AW{1'b0}}, 1'b1};
            len_q           <= count_q;
            state_q         <= RUN;
          end
        end

        RUN: begin
          if (ptr_q == len_q) begin
            weights_out_q   <= '0;
            weights_valid_q <= 1'b0;
            v0_q            <= 1'b0;
            state_q         <= DRAIN;
          end else begin
            weights_out_q <= bank_q[ptr_q[AW-1:0]];
            v0_q          <= 1'b1;
            i0_q          <= ptr_q[AW-1:0];
            ptr_q         <= ptr_q + 1'b1;
          end
        end

        DRAIN: begin
          // Only the last index is still in flight once the bank has been exhausted.
          if (v1_q) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef TERNARY_FIRE_MASK_EN
  logic [DEPTH-1:0] fire_mask_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fire_mask_q <= '0;
    end else if (start_ok) begin
      fire_mask_q <= '0;
    end else if (v1_q) begin
      fire_mask_q[i1_q] <= ($signed(sum_in) > 4'sd0);
    end
  end

  assign fire_mask = fire_mask_q;
`endif

endmodule

// File: tb/tb_ternary_weight_sequencer.sv
// Self-checking bench for ternary_weight_sequencer: directed table, busy/abort sequences and a
// randomized run against a perceptron + argmax reference model.
module tb_ternary_weight_sequencer;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          load_valid;
  logic [7:0]    load_data;
  logic          load_ready;
  logic          start;
  logic          busy;
  logic [7:0]    weights_out;
  logic          weights_valid;
  logic [3:0]    sum_in;
  logic          done;
  logic [AW-1:0] best_idx;
  logic [3:0]    best_sum;
`ifdef TERNARY_FIRE_MASK_EN
  logic [DEPTH-1:0] fire_mask;
`endif

  logic [3:0] x_in;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ternary_weight_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .load_ready    (load_ready),
    .start         (start),
    .busy          (busy),
    .weights_out   (weights_out),
    .weights_valid (weights_valid),
    .sum_in        (sum_in),
    .done          (done),
    .best_idx      (best_idx),
    .best_sum      (best_sum)
`ifdef TERNARY_FIRE_MASK_EN
    ,
    .fire_mask     (fire_mask)
`endif
  );

  // Ternary dot product of a packed weight byte with 4 binary inputs.
  function automatic logic [3:0] dot(input logic [7:0] w, input logic [3:0] x);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      if (x[i] === 1'b1) begin
        if (w[2*i +: 2] == 2'b01) s++;
        else if (w[2*i +: 2] == 2'b11) s--;
      end
    end
    return 4'(s);
  endfunction

  // Registered perceptron model: one edge from weights to sum.
  always @(posedge clk) sum_in <= dot(weights_out, x_in);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_bank(input int n, input logic [31:0] w);
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int k = 0; k < n; k++) begin
      load_valid = 1'b1;
      load_data  = w[8*k +: 8];
      check("load_ready_fill", load_ready, 1'b1);
      step();
    end
    load_valid = 1'b0;
  endtask

  // Starts a run, follows the replayed weights and checks the result at done.
  task automatic run_check(input int n, input logic [31:0] w, input logic [AW-1:0] eidx,
                           input logic [3:0] esum, input logic [3:0] emask, input bit noise);
    bit seen;
    seen  = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_busy", busy, 1'b1);
    check("start_valid", weights_valid, 1'b1);
    check("start_w0", weights_out, w[7:0]);
    for (int cyc = 1; cyc <= 12 && !seen; cyc++) begin
      if (noise && cyc == 1) begin
        start      = 1'b1;
        clear      = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'hC3;
        check("busy_load_ready", load_ready, 1'b0);
      end
      step();
      start      = 1'b0;
      clear      = 1'b0;
      load_valid = 1'b0;
      if (cyc < n) begin
        check("replay_w", weights_out, w[8*cyc +: 8]);
        check("replay_valid", weights_valid, 1'b1);
      end else if (cyc == n) begin
        check("end_w_zero", weights_out, 8'h00);
        check("end_valid_low", weights_valid, 1'b0);
      end
      if (done === 1'b1) begin
        seen = 1'b1;
        check("done_latency", cyc, n + 1);
      end
    end
    if (!seen) check("done_timeout", 1'b0, 1'b1);
    check("best_idx", best_idx, eidx);
    check("best_sum", best_sum, esum);
    check("done_busy_low", busy, 1'b0);
`ifdef TERNARY_FIRE_MASK_EN
    check("fire_mask", fire_mask, emask);
`endif
    step();
    check("done_one_cycle", done, 1'b0);
    check("best_sum_held", best_sum, esum);
    check("best_idx_held", best_idx, eidx);
    if (emask === 4'bx) check("mask_arg", 1'b0, 1'b1);
  endtask

  typedef struct packed {
    logic [2:0]    n;
    logic [31:0]   w;
    logic [3:0]    x;
    logic [AW-1:0] exp_idx;
    logic [3:0]    exp_sum;
    logic [3:0]    exp_mask;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int            n;
    logic [31:0]   w;
    logic [3:0]    sums [4];
    logic [AW-1:0] m_idx;
    logic [3:0]    m_mask;

    vecs[0] = '{n: 3'd4, w: 32'h15FF5500, x: 4'b1111, exp_idx: 2'd1, exp_sum: 4'd4, exp_mask: 4'b1010};
    vecs[1] = '{n: 3'd2, w: 32'h00000401, x: 4'b1111, exp_idx: 2'd0, exp_sum: 4'd1, exp_mask: 4'b0011};
    vecs[2] = '{n: 3'd2, w: 32'h00003FFF, x: 4'b1111, exp_idx: 2'd1, exp_sum: 4'b1101, exp_mask: 4'b0000};
    vecs[3] = '{n: 3'd3, w: 32'h00415555, x: 4'b0011, exp_idx: 2'd0, exp_sum: 4'd2, exp_mask: 4'b0111};
    vecs[4] = '{n: 3'd1, w: 32'h0000000D, x: 4'b0001, exp_idx: 2'd0, exp_sum: 4'd1, exp_mask: 4'b0001};

    reset = 1'b1; clear = 1'b0; load_valid = 1'b0; load_data = '0; start = 1'b0; x_in = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_wvalid", weights_valid, 1'b0);
    check("rst_wout", weights_out, 8'h00);
    check("rst_best_idx", best_idx, '0);
    check("rst_best_sum", best_sum, 4'h0);
    check("rst_load_ready", load_ready, 1'b0);
`ifdef TERNARY_FIRE_MASK_EN
    check("rst_fire_mask", fire_mask, 4'h0);
`endif
    reset = 1'b0;
    #1;
    check("post_rst_load_ready", load_ready, 1'b1);
    step();

    for (int i = 0; i < 5; i++) begin
      x_in = vecs[i].x;
      load_bank(int'(vecs[i].n), vecs[i].w);
      run_check(int'(vecs[i].n), vecs[i].w, vecs[i].exp_idx, vecs[i].exp_sum, vecs[i].exp_mask, 1'b0);
    end

    // Bank survives runs; start/clear/load during a run are ignored.
    x_in = 4'b1111;
    load_bank(4, vecs[0].w);
    run_check(4, vecs[0].w, 2'd1, 4'd4, 4'b1010, 1'b1);
    run_check(4, vecs[0].w, 2'd1, 4'd4, 4'b1010, 1'b0);

    // Full bank drops a fifth byte; clear empties it and start is then ignored.
    load_bank(4, vecs[0].w);
    load_valid = 1'b1;
    load_data  = 8'hAA;
    check("full_load_ready", load_ready, 1'b0);
    step();
    load_valid = 1'b0;
    run_check(4, vecs[0].w, 2'd1, 4'd4, 4'b1010, 1'b0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_load_ready", load_ready, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("empty_start_busy", busy, 1'b0);
    step();
    check("empty_start_busy2", busy, 1'b0);
    check("empty_start_wvalid", weights_valid, 1'b0);
    check("empty_start_done", done, 1'b0);

    // Randomized runs against the reference model.
    for (int it = 0; it < 25; it++) begin
      n    = int'($urandom_range(1, 4));
      w    = $urandom;
      x_in = 4'($urandom);
      for (int k = 0; k < 4; k++) sums[k] = dot(w[8*k +: 8], x_in);
      m_idx  = '0;
      m_mask = '0;
      for (int k = 0; k < n; k++) begin
        if ($signed(sums[k]) > $signed(sums[m_idx])) m_idx = AW'(k);
        if ($signed(sums[k]) > 0) m_mask[k] = 1'b1;
      end
      load_bank(n, w);
      run_check(n, w, m_idx, sums[m_idx], m_mask, 1'b0);
    end

    // Reset at edge S+2 of a 4-entry run aborts without a done pulse.
    x_in = 4'b1111;
    load_bank(4, vecs[0].w);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    @(posedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_wvalid", weights_valid, 1'b0);
    check("abort_wout", weights_out, 8'h00);
    check("abort_done", done, 1'b0);
    check("abort_best_idx", best_idx, '0);
    check("abort_best_sum", best_sum, 4'h0);
    check("abort_load_ready", load_ready, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step();
      check("abort_no_done", done, 1'b0);
    end
    reset = 1'b0;
    #1;
    check("abort_release_ready", load_ready, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("abort_count_zero", busy, 1'b0);
    step();
    check("abort_no_done_after", done, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
